// File: rtl/booth_issue_ctrl_pkg.sv
// Shared definitions for the Booth multiplier issue/capture stage.
package booth_issue_ctrl_pkg;

   // Sequencer states: wait for work, reset the multiplier, run it, hand off the product.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RUN     = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   // One operand-latch step plus one step per radix-4 digit pair.
   localparam int DEFAULT_ITER_CYCLES = DEFAULT_WIDTH / 2 + 1;

endpackage

// File: rtl/booth_issue_ctrl_if.sv
// Operand input stream and product output stream of the issue stage.
interface booth_issue_ctrl_if #(
   parameter int WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_product;

   // Producer/consumer side (bench or surrounding pipeline).
   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   // Issue stage side.
   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/booth_operand_fifo.sv
// Small operand-pair FIFO; head is readable combinationally so the
// sequencer can pop and latch operands in the same cycle.
module booth_operand_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_a,
   input  logic [WIDTH-1:0] push_b,
   input  logic             pop,
   output logic [WIDTH-1:0] head_a,
   output logic [WIDTH-1:0] head_b,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr_reg;
   logic [AW:0]        rd_ptr_reg;
   logic               push_ok;
   logic               pop_ok;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign {head_a, head_b} = mem[rd_ptr_reg[AW-1:0]];

   // Pointer update; reset drops all queued pairs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
   end

   // Storage write; contents are meaningless until the write pointer covers them.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= {push_a, push_b};
   end

endmodule

// File: rtl/radix4BoothWithRegs.sv
// Iterative radix-4 Booth multiplier: operands latched on reset, one
// digit pair retired per enabled cycle, result frozen once all pairs are done.
module radix4BoothWithRegs #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               resetIntegration,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result
);
   localparam int STEPS = WIDTH / 2;
   localparam int SW    = $clog2(STEPS + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH:0]     mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [SW-1:0]      step_reg;
   logic [2*WIDTH-1:0] pp;

   // Booth digit selection from the low three multiplier bits.
   always_comb begin
      pp = '0;
      case (mplier_reg[2:0])
         3'b001, 3'b010: pp = mcand_reg;
         3'b011:         pp = mcand_reg << 1;
         3'b100:         pp = -(mcand_reg << 1);
         3'b101, 3'b110: pp = -mcand_reg;
         default:        pp = '0;
      endcase
   end

   // Accumulate one shifted partial product per enabled cycle.
   always_ff @(posedge clk or posedge resetIntegration) begin
      if (resetIntegration) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         step_reg   <= '0;
      end else if (reset) begin
         mcand_reg  <= {{WIDTH{a[WIDTH-1]}}, a};
         mplier_reg <= {b, 1'b0};
         acc_reg    <= '0;
         step_reg   <= '0;
      end else if (en && (step_reg != LAST_STEP)) begin
         acc_reg    <= acc_reg + pp;
         mcand_reg  <= mcand_reg << 2;
         mplier_reg <= {2'b00, mplier_reg[WIDTH:2]};
         step_reg   <= step_reg + SW'(1);
      end
   end

   assign result = acc_reg;

endmodule

// File: rtl/booth_issue_ctrl.sv
// Feeds queued operand pairs to the Booth multiplier one job at a time and
// holds each finished product in an output register with backpressure.
module booth_issue_ctrl
   import booth_issue_ctrl_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int ITER_CYCLES = DEFAULT_ITER_CYCLES,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   booth_issue_ctrl_if.slave    bus,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   output logic                 mult_reset,
   output logic                 mult_reset_int,
   output logic                 mult_en,
   input  logic [2*WIDTH-1:0]   mult_product,
   output logic                 busy,
   output logic [CNT_W-1:0]     done_count
);
   localparam int CW = $clog2(ITER_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(ITER_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [WIDTH-1:0]   mult_a_reg, mult_b_reg;
   logic               mult_reset_reg, mult_reset_next;
   logic               mult_en_reg, mult_en_next;
   logic               mult_reset_int_reg;
   logic               out_valid_reg;
   logic [2*WIDTH-1:0] out_product_reg;
   logic [CNT_W-1:0]   done_count_reg;

   logic               fifo_full, fifo_empty;
   logic [WIDTH-1:0]   head_a, head_b;
   logic               pop;
   logic               capture;
   logic               deliver;

   booth_operand_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (reset),
      .push   (bus.in_valid),
      .push_a (bus.in_a),
      .push_b (bus.in_b),
      .pop    (pop),
      .head_a (head_a),
      .head_b (head_b),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign bus.in_ready = !fifo_full;
   assign deliver      = out_valid_reg && bus.out_ready;

   // State register plus multiplier-facing registers (reset/enable track the next state).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg          <= IDLE;
         cnt_reg            <= '0;
         mult_a_reg         <= '0;
         mult_b_reg         <= '0;
         mult_reset_reg     <= 1'b1;
         mult_en_reg        <= 1'b0;
         mult_reset_int_reg <= 1'b1;
      end else begin
         state_reg          <= state_next;
         cnt_reg            <= cnt_next;
         mult_reset_reg     <= mult_reset_next;
         mult_en_reg        <= mult_en_next;
         mult_reset_int_reg <= 1'b0;
         if (pop) begin
            mult_a_reg <= head_a;
            mult_b_reg <= head_b;
         end
      end
   end

   // Next-state logic: LOAD is a single reset cycle, RUN lasts ITER_CYCLES cycles.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE:    if (!fifo_empty) state_next = LOAD;
         LOAD: begin
            state_next = RUN;
            cnt_next   = '0;
         end
         RUN: begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == LAST_CNT) state_next = CAPTURE;
         end
         CAPTURE: if (!out_valid_reg || bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: pop/capture strobes and next values of the registered multiplier controls.
   always_comb begin
      pop             = (state_reg == IDLE) && !fifo_empty;
      capture         = (state_reg == CAPTURE) && (!out_valid_reg || bus.out_ready);
      mult_reset_next = (state_next == LOAD);
      mult_en_next    = (state_next == RUN);
      busy            = (state_reg != IDLE);
   end

   // Result register and delivery counter; a capture overrides a same-cycle drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_reg   <= 1'b0;
         out_product_reg <= '0;
         done_count_reg  <= '0;
      end else begin
         if (capture) begin
            out_product_reg <= mult_product;
            out_valid_reg   <= 1'b1;
         end else if (deliver) begin
            out_valid_reg   <= 1'b0;
         end
         if (deliver) done_count_reg <= done_count_reg + CNT_W'(1);
      end
   end

   assign mult_a          = mult_a_reg;
   assign mult_b          = mult_b_reg;
   assign mult_reset      = mult_reset_reg;
   assign mult_reset_int  = mult_reset_int_reg;
   assign mult_en         = mult_en_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_product = out_product_reg;
   assign done_count      = done_count_reg;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Bench: issue stage driving the Booth multiplier, checked against a
// queue-of-products model plus directed literal expectations.
module tb_booth_issue_ctrl;
   localparam int WIDTH = 32;
   localparam int ITER  = 17;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;   // small counter so the wrap is reachable

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   booth_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

   logic [WIDTH-1:0]   mult_a, mult_b;
   logic               mult_reset, mult_reset_int, mult_en;
   logic [2*WIDTH-1:0] mult_product;
   logic               busy;
   logic [CNT_W-1:0]   done_count;

   booth_issue_ctrl #(
      .WIDTH(WIDTH), .ITER_CYCLES(ITER), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(rst), .bus(bus),
      .mult_a(mult_a), .mult_b(mult_b), .mult_reset(mult_reset),
      .mult_reset_int(mult_reset_int), .mult_en(mult_en),
      .mult_product(mult_product), .busy(busy), .done_count(done_count)
   );

   radix4BoothWithRegs #(.WIDTH(WIDTH)) u_mul (
      .clk(clk), .reset(mult_reset), .resetIntegration(mult_reset_int),
      .en(mult_en), .a(mult_a), .b(mult_b), .result(mult_product)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- model: accepted pairs -> expected products, in order
   logic [63:0]        exp_q[$];
   int                 done_exp;
   bit                 held_valid;
   logic [63:0]        held_product;
   logic signed [63:0] ma, mb;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         done_exp   = 0;
         held_valid = 1'b0;
      end else begin
         check("done_count", 64'(done_count), 64'(done_exp % (1 << CNT_W)));
         if (held_valid) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_product", bus.out_product, held_product);
         end
         held_valid   = bus.out_valid && !bus.out_ready;
         held_product = bus.out_product;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", bus.out_product);
            end else begin
               check("product", bus.out_product, exp_q.pop_front());
               done_exp++;
               $display("out: product=%0d delivered=%0d", $signed(bus.out_product), done_exp);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            ma = 64'($signed(bus.in_a));
            mb = 64'($signed(bus.in_b));
            exp_q.push_back(ma * mb);
            $display("in: a=%0d b=%0d", $signed(bus.in_a), $signed(bus.in_b));
         end
      end
   end

   // ---------------- directed stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          first, rcnt, ecnt, n, base, seen;
   logic [63:0] prod;
   logic [63:0] got [4];
   int          cyc [4];
   logic [63:0] dsamp [4];
   logic [63:0] exp_t2 [4];
   logic        rdy [6];

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
      repeat (3) tick();
      // reset values
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_mult_reset", 64'(mult_reset), 64'd1);
      check("rst_mult_reset_int", 64'(mult_reset_int), 64'd1);
      check("rst_mult_en", 64'(mult_en), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_product", bus.out_product, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_count", 64'(done_count), 64'd0);
      check("rst_mult_a", 64'(mult_a), 64'd0);
      rst = 1'b0;
      tick();
      check("mult_reset_int_released", 64'(mult_reset_int), 64'd0);
      check("mult_reset_idle", 64'(mult_reset), 64'd0);

      // T1: single job 5 * -7, latency and pulse widths
      bus.in_a = 32'd5; bus.in_b = -32'sd7; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      first = 0; rcnt = 0; ecnt = 0; prod = '0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         rcnt += int'(mult_reset);
         ecnt += int'(mult_en);
         if (bus.out_valid && first == 0) begin
            first = k;
            prod  = bus.out_product;
         end
      end
      check("t1_latency", 64'(first), 64'd20);
      check("t1_reset_cycles", 64'(rcnt), 64'd1);
      check("t1_en_cycles", 64'(ecnt), 64'd17);
      check("t1_product", prod, 64'hFFFF_FFFF_FFFF_FFDD);
      check("t1_mult_a_held", 64'(mult_a), 64'd5);
      check("t1_done_count", 64'(done_count), 64'd1);

      // T2: four back-to-back pushes, order, spacing, counter wrap
      exp_t2[0] = 64'd6; exp_t2[1] = 64'd48; exp_t2[2] = 64'hFFFF_FFFF_FFFF_FFD3; exp_t2[3] = 64'd0;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin bus.in_a = 32'd2;    bus.in_b = 32'd3;    end
            1: begin bus.in_a = -32'sd12; bus.in_b = -32'sd4;  end
            2: begin bus.in_a = -32'sd9;  bus.in_b = 32'd5;    end
            default: begin bus.in_a = 32'd11; bus.in_b = 32'd0; end
         endcase
         bus.in_valid = 1'b1;
         check("t2_in_ready", 64'(bus.in_ready), 64'd1);
         tick();
      end
      bus.in_valid = 1'b0;
      n = 0;
      for (int c = 1; c <= 120; c++) begin
         tick();
         if (bus.out_valid && n < 4) begin
            got[n]   = bus.out_product;
            cyc[n]   = c;
            dsamp[n] = 64'(done_count);
            n++;
         end
      end
      check("t2_count", 64'(n), 64'd4);
      for (int i = 0; i < 4; i++) check("t2_product", got[i], exp_t2[i]);
      for (int i = 1; i < 4; i++) check("t2_spacing", 64'(cyc[i] - cyc[i-1]), 64'd20);
      // counter before deliveries 2..5 of the run: 1,2,3 then wrapped to 0
      check("t2_cnt_before2", dsamp[0], 64'd1);
      check("t2_cnt_before4", dsamp[2], 64'd3);
      check("t2_cnt_wrapped", dsamp[3], 64'd0);
      check("t2_done_count", 64'(done_count), 64'd1);

      // T3: backpressure; six attempts while out_ready=0
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.in_a = (i == 0) ? 32'd10 : 32'(i + 1);
         bus.in_b = (i == 0) ? 32'd1  : 32'(i + 2);
         bus.in_valid = 1'b1;
         rdy[i] = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) check("t3_in_ready_open", 64'(rdy[i]), 64'd1);
      check("t3_in_ready_full", 64'(rdy[5]), 64'd0);
      repeat (60) tick();
      check("t3_held_valid", 64'(bus.out_valid), 64'd1);
      check("t3_held_product", bus.out_product, 64'd10);
      check("t3_stall_busy", 64'(busy), 64'd1);
      check("t3_stall_en", 64'(mult_en), 64'd0);
      check("t3_in_ready_after", 64'(bus.in_ready), 64'd1);
      base = done_exp;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 400 && seen == 0; c++) begin
         tick();
         if (exp_q.size() == 0 && !busy && !bus.out_valid) seen = 1;
      end
      check("t3_drain_done", 64'(seen), 64'd1);
      check("t3_delivered", 64'(done_exp - base), 64'd5);

      // T4: reset in the 8th RUN cycle of (4,6) with (-1,-7) queued
      bus.in_a = 32'd4; bus.in_b = 32'd6; bus.in_valid = 1'b1;
      tick();
      bus.in_a = -32'sd1; bus.in_b = -32'sd7;
      tick();
      bus.in_valid = 1'b0;
      ecnt = int'(mult_en);
      for (int c = 0; c < 50 && ecnt < 8; c++) begin
         tick();
         ecnt += int'(mult_en);
      end
      check("t4_reached_run8", 64'(ecnt), 64'd8);
      rst = 1'b1;
      #2;
      check("t4_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("t4_rst_mult_reset", 64'(mult_reset), 64'd1);
      check("t4_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("t4_rst_done_count", 64'(done_count), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.out_valid) seen = 1;
      end
      check("t4_no_output", 64'(seen), 64'd0);
      check("t4_fifo_empty_idle", 64'(busy), 64'd0);
      bus.in_a = -32'sd1; bus.in_b = -32'sd7; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      first = 0; prod = '0;
      for (int k = 1; k <= 40 && first == 0; k++) begin
         tick();
         if (bus.out_valid) begin
            first = k;
            prod  = bus.out_product;
         end
      end
      check("t4_latency", 64'(first), 64'd20);
      check("t4_product", prod, 64'd7);
      tick();
      check("t4_done_count", 64'(done_count), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
